dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Shares the CPU's single data-memory port between the pipeline's M-stage access and a burst DMA requester. It sits between the CPU data bus and the data memory. The CPU has absolute priority because the pipeline cannot stall on memory; DMA beats fill idle cycles. A starvation monitor can raise an interrupt line for one `HWInt` bit.

## Interface
- `MAX_BURST`, default 16: largest burst length in words. The `dma_len` value 0 encodes `MAX_BURST`.
- `STARVE_LIMIT`, default 8: number of consecutive blocked DMA cycles before `starve_irq` is raised.
- `clk` in 1: the single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-low. Sampled on the `clk` rising edge.
- `cpu_addr` in 32: M-stage data address.
- `cpu_wdata` in 32: M-stage store data, already lane-replicated.
- `cpu_byteen` in 4: store byte enables. Any nonzero value is a write.
- `cpu_rd` in 1: M-stage load in progress.
- `cpu_rdata` out 32: load data, equal to `mem_rdata`.
- `dma_req` in 1: DMA burst request. Held high until `dma_gnt`.
- `dma_addr` in 32: burst start address. Bits [1:0] are ignored.
- `dma_len` in 5: burst length in words. Value 0 means `MAX_BURST`.
- `dma_we` in 1: 1 for a write burst, 0 for a read burst.
- `dma_wdata` in 32: current write word. The source advances it on `dma_beat`.
- `dma_gnt` out 1: one-cycle pulse when a burst is accepted.
- `dma_beat` out 1: a DMA beat is on the memory port this cycle.
- `dma_rvalid` out 1: `dma_rdata` is valid this cycle.
- `dma_rdata` out 32: read-beat data.
- `dma_done` out 1: one-cycle pulse when a burst completes.
- `mem_addr` out 32, `mem_wdata` out 32, `mem_byteen` out 4, `mem_rd` out 1: memory-port command. Read data returns the cycle after `mem_rd`.
- `mem_rdata` in 32: memory read data.
- `starve_irq` out 1: starvation flag, routed to `HWInt`.

## Operation
- **CPU access:** `cpu_act = cpu_rd | (|cpu_byteen)`. When `cpu_act` is 1, the memory port carries the CPU command unconditionally.
- **Default mux:** when no DMA beat is issued, the memory port follows the CPU inputs. `mem_rd` and `mem_byteen` are 0 when the CPU is inactive.
- **FSM states:** IDLE, BURST, DONE.
- **IDLE:**
  - If `dma_req` = 1: latch `addr_q = {dma_addr[31:2], 2'b00}`, `rem_q = (dma_len == 0) ? MAX_BURST : dma_len`, `we_q = dma_we`, then go to BURST.
  - Otherwise stay in IDLE.
- **BURST, DMA beat:** a beat is issued when `!cpu_act`.
  - `dma_beat` = 1 and `mem_addr = addr_q`.
  - Write burst: `mem_byteen = 4'hF`, `mem_wdata = dma_wdata`.
  - Read burst: `mem_rd` = 1.
  - Update: `addr_q += 4`, wrapping modulo 2^32; `rem_q -= 1`.
- **BURST, exit:** on the beat that makes `rem_q` reach 0, go to DONE.
- **BURST, CPU wins:** if `cpu_act` = 1, no beat is issued and `rem_q` is unchanged.
- **DONE:** `dma_done` = 1 for this one cycle, then go to IDLE. `dma_req` is ignored while in DONE.
- **Read routing:**
  - A registered flag `dma_rd_q` = DMA read beat issued last cycle.
  - `dma_rvalid = dma_rd_q` and `dma_rdata = mem_rdata`.
  - `cpu_rdata = mem_rdata` at all times. The CPU qualifies it with its own W-stage load.
- **Reset:**
  - Any state goes to IDLE, clears `rem_q`, `addr_q`, `dma_rd_q`, the grant register and the starvation state.
  - An in-flight burst is aborted with no `dma_done` and no further `dma_rvalid`.

## Timing
- **Reset values:** `dma_gnt`, `dma_beat`, `dma_rvalid`, `dma_done` and `starve_irq` are all 0. Memory outputs follow the CPU inputs.
- **Grant:** `dma_req` = 1 sampled in IDLE at edge N gives `dma_gnt` = 1 during cycle N+1, the first BURST cycle. The first beat can occur in that same cycle.
- **Read data:** a read beat in cycle k gives `dma_rvalid` in cycle k+1.
- **Completion:** `dma_done` is asserted in the cycle after the last beat. For read bursts the last `dma_rvalid` coincides with `dma_done`.
- **Minimum burst time:** a burst of L words with no CPU traffic occupies L BURST cycles plus 1 DONE cycle. The next grant is no earlier than 2 cycles after `dma_done`'s edge: DONE→IDLE, then IDLE→BURST.
- **CPU load, memory side:** the CPU load data path is unaffected. `mem_rd` in cycle k means `cpu_rdata` is valid in cycle k+1.
- **CPU access during a DMA read:** a CPU access in cycle k+1 does not corrupt a DMA read issued in cycle k, because the data for each is returned in distinct cycles.

## Configuration
- **`ARB_STARVE_IRQ_EN` defined:** a counter tracks consecutive BURST cycles with `cpu_act` = 1.
  - The counter saturates at `STARVE_LIMIT`.
  - When it reaches `STARVE_LIMIT`, `starve_irq` is set on the next edge.
  - A beat clears the counter, but `starve_irq` stays set.
  - `starve_irq` is cleared in the DONE cycle or by reset.
- **Not defined:** `starve_irq` is constant 0 and no counter logic is synthesized.

## Test plan
- **Idle read burst:**
  - Stimulus: `reset` low for 2 cycles, then `dma_req` with `dma_addr` = 0x3001, `dma_len` = 4, `dma_we` = 0; CPU idle.
  - Required: `dma_gnt` in cycle 1; beats at 0x3000, 0x3004, 0x3008, 0x300C in cycles 1–4; `dma_rvalid` in cycles 2–5; `dma_done` in cycle 5.
- **CPU preemption:**
  - Stimulus: write burst with `dma_len` = 2; `cpu_byteen` = 4'hF at 0x10 in the first BURST cycle.
  - Required: the memory port shows the CPU store; the DMA beat is deferred; beats occur in BURST cycles 2–3; `dma_done` in the cycle after.
- **Length 0 with wrap:**
  - Stimulus: `dma_len` = 0, `dma_addr` = 0xFFFFFFF8.
  - Required: 16 beats; addresses wrap 0xFFFFFFFC → 0x00000000.
- **Starvation (`ARB_STARVE_IRQ_EN`):**
  - Stimulus: `cpu_rd` held high for 10 BURST cycles.
  - Required: `starve_irq` rises after 8 blocked cycles and clears in the DONE cycle.
- **Reset mid-burst:**
  - Stimulus: assert `reset` low after 2 of 8 beats.
  - Required: next cycle in IDLE with `dma_rvalid` = 0; no `dma_done`; a new `dma_req` is granted normally.
- **Back-to-back requests:**
  - Stimulus: `dma_req` held high through DONE.
  - Required: no grant during DONE; second `dma_gnt` exactly 2 cycles after the first `dma_done`.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//
// Shares the single data-memory port between the CPU M-stage access and a
// burst DMA requester. The CPU always wins the port because the pipeline
// cannot stall on memory; DMA beats are issued only in cycles where the CPU
// is not accessing memory.
//
// Parameters
//   MAX_BURST     largest burst length in words (dma_len == 0 encodes it)
//   STARVE_LIMIT  consecutive blocked BURST cycles before starve_irq is raised
//
// Ports
//   clk, reset                 clock; synchronous active-low reset
//   cpu_addr/wdata/byteen/rd   M-stage command (byteen != 0 means store)
//   cpu_rdata                  load data, always mem_rdata
//   dma_req/addr/len/we/wdata  burst request and current write word
//   dma_gnt                    one-cycle pulse in the first BURST cycle
//   dma_beat                   a DMA beat owns the memory port this cycle
//   dma_rvalid/rdata           read-beat data, one cycle after the beat
//   dma_done                   one-cycle pulse after the last beat
//   mem_addr/wdata/byteen/rd   memory command; read data returns next cycle
//   mem_rdata                  memory read data
//   starve_irq                 starvation flag for one HWInt bit
//
// Optional feature: define ARB_STARVE_IRQ_EN to build the starvation monitor.
// Without it starve_irq is tied to 0 and no counter exists.

module dmem_port_arbiter #(
    parameter int MAX_BURST    = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    input  logic        cpu_rd,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [4:0]  dma_len,
    input  logic        dma_we,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_beat,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        dma_done,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    output logic        starve_irq
);

    localparam int REM_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       addr_q;
    logic [REM_W-1:0]  rem_q;
    logic              we_q;
    logic              gnt_q;
    logic              dma_rd_q;
    logic              cpu_act;
    logic              beat;
    logic              last_beat;
    logic              accept;

    // Word alignment drops the low address bits of the burst start.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^dma_addr[1:0];

    assign cpu_act   = cpu_rd | (|cpu_byteen);
    assign beat      = (state == BURST) && !cpu_act;
    assign last_beat = beat && (rem_q == REM_W'(1));
    assign accept    = (state == IDLE) && dma_req;

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dma_req) state_nxt = BURST;
            BURST:   if (last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- burst bookkeeping ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q   <= 32'd0;
            rem_q    <= '0;
            we_q     <= 1'b0;
            gnt_q    <= 1'b0;
            dma_rd_q <= 1'b0;
        end else begin
            gnt_q    <= accept;
            // Memory returns read data one cycle after mem_rd, so the read
            // flag is delayed by exactly one cycle to qualify dma_rdata.
            dma_rd_q <= beat && !we_q;
            if (accept) begin
                addr_q <= {dma_addr[31:2], 2'b00};
                rem_q  <= (dma_len == 5'd0) ? REM_W'(MAX_BURST) : REM_W'(dma_len);
                we_q   <= dma_we;
            end else if (beat) begin
                addr_q <= addr_q + 32'd4;
                rem_q  <= rem_q - REM_W'(1);
            end
        end
    end

    // ---- memory port mux ----
    always_comb begin
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_byteen = cpu_byteen;
        mem_rd     = cpu_rd;
        if (beat) begin
            mem_addr   = addr_q;
            mem_wdata  = dma_wdata;
            mem_byteen = we_q ? 4'hF : 4'h0;
            mem_rd     = !we_q;
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;
    assign dma_rvalid = dma_rd_q;
    assign dma_gnt    = gnt_q;
    assign dma_beat   = beat;
    assign dma_done   = (state == DONE);

`ifdef ARB_STARVE_IRQ_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starve_q;

    // ---- starvation monitor ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
            starve_q   <= 1'b0;
        end else begin
            // Counts only consecutive blocked BURST cycles; any beat or
            // leaving BURST restarts the count.
            if ((state == BURST) && cpu_act) begin
                if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
            // The flag is sticky across beats and only drops at burst end.
            if (state == DONE) begin
                starve_q <= 1'b0;
            end else if (starve_cnt == CNT_W'(STARVE_LIMIT)) begin
                starve_q <= 1'b1;
            end
        end
    end

    assign starve_irq = starve_q;
`else
    assign starve_irq = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: table-driven single-cycle vectors plus
// hand-written sequences for wrap, starvation, reset abort and back-to-back.

module tb_dmem_port_arbiter;

    localparam logic [31:0] CW  = 32'h1234_5678;
    localparam logic [31:0] DW  = 32'hCAFE_0001;
    localparam logic [31:0] RDX = 32'h5A5A_0000;
`ifdef ARB_STARVE_IRQ_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic        cpu_rd;
    logic [31:0] cpu_rdata;
    logic        dma_req;
    logic [31:0] dma_addr;
    logic [4:0]  dma_len;
    logic        dma_we;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_beat;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic        dma_done;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        starve_irq;

    int total;
    int bad;

    dmem_port_arbiter #(.MAX_BURST(16), .STARVE_LIMIT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_byteen (cpu_byteen),
        .cpu_rd     (cpu_rd),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_len    (dma_len),
        .dma_we     (dma_we),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_beat   (dma_beat),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .dma_done   (dma_done),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_byteen (mem_byteen),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .starve_irq (starve_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data is a fixed function of the address, one cycle later.
    always @(posedge clk) begin
        mem_rdata <= mem_rd ? (mem_addr ^ RDX) : 32'h0;
    end

    typedef struct {
        logic [31:0] c_addr;
        logic [3:0]  c_be;
        logic        c_rd;
        logic        d_req;
        logic [31:0] d_addr;
        logic [4:0]  d_len;
        logic        d_we;
        logic        e_gnt;
        logic        e_beat;
        logic        e_rv;
        logic        e_done;
        logic [31:0] e_addr;
        logic        e_rd;
        logic [3:0]  e_be;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_addr   = 32'h100;
        cpu_byteen = 4'h0;
        cpu_rd     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0]  bb_gnt;
        logic [5:0]  bb_done;
        logic [31:0] exp_a;
        int          beats;
        logic        done_seen;
        logic        e_irq;

        total = 0;
        bad   = 0;

        // Idle read burst, 4 words from 0x3001
        vq.push_back('{32'h100, 4'h0, 1'b0, 1'b1, 32'h3001, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100,  1'b0, 4'h0, 32'h0});
        vq.push_back('{32'h100, 4'h0, 1'b0, 1'b1, 32'h3001, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h3000, 1'b1, 4'h0, 32'h0});
        vq.push_back('{32'h100, 4'h0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3004, 1'b1, 4'h0, 32'h5A5A3000});
        vq.push_back('{32'h100, 4'h0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3008, 1'b1, 4'h0, 32'h5A5A3004});
        vq.push_back('{32'h100, 4'h0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300C, 1'b1, 4'h0, 32'h5A5A3008});
        vq.push_back('{32'h100, 4'h0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100,  1'b0, 4'h0, 32'h5A5A300C});
        vq.push_back('{32'h100, 4'h0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100,  1'b0, 4'h0, 32'h0});
        // CPU store preempts the first write-burst cycle
        vq.push_back('{32'h100, 4'h0, 1'b0, 1'b1, 32'h400,  5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100,  1'b0, 4'h0, 32'h0});
        vq.push_back('{32'h10,  4'hF, 1'b0, 1'b1, 32'h400,  5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10,   1'b0, 4'hF, 32'h0});
        vq.push_back('{32'h100, 4'h0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h400,  1'b0, 4'hF, 32'h0});
        vq.push_back('{32'h100, 4'h0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h404,  1'b0, 4'hF, 32'h0});
        vq.push_back('{32'h100, 4'h0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100,  1'b0, 4'h0, 32'h0});
        vq.push_back('{32'h100, 4'h0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100,  1'b0, 4'h0, 32'h0});
        // CPU load right after a DMA read beat; data returned in distinct cycles
        vq.push_back('{32'h100, 4'h0, 1'b0, 1'b1, 32'h800,  5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100,  1'b0, 4'h0, 32'h0});
        vq.push_back('{32'h100, 4'h0, 1'b0, 1'b1, 32'h800,  5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h800,  1'b1, 4'h0, 32'h0});
        vq.push_back('{32'h20,  4'h0, 1'b1, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20,   1'b1, 4'h0, 32'h5A5A0800});
        vq.push_back('{32'h100, 4'h0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h804,  1'b1, 4'h0, 32'h0});
        vq.push_back('{32'h100, 4'h0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100,  1'b0, 4'h0, 32'h5A5A0804});
        vq.push_back('{32'h100, 4'h0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100,  1'b0, 4'h0, 32'h0});

        // Reset
        reset     = 1'b0;
        cpu_wdata = CW;
        dma_wdata = DW;
        cpu_idle();
        cpu_addr  = 32'h44;
        dma_req   = 1'b0;
        dma_addr  = 32'h0;
        dma_len   = 5'd0;
        dma_we    = 1'b0;
        next_cycle();
        next_cycle();
        #4;
        chk("rst_gnt",    dma_gnt,    1'b0);
        chk("rst_beat",   dma_beat,   1'b0);
        chk("rst_rvalid", dma_rvalid, 1'b0);
        chk("rst_done",   dma_done,   1'b0);
        chk("rst_irq",    starve_irq, 1'b0);
        chk("rst_maddr",  mem_addr,   32'h44);
        chk("rst_mbe",    mem_byteen, 4'h0);
        chk("rst_mrd",    mem_rd,     1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Table vectors
        foreach (vq[i]) begin
            cpu_addr   = vq[i].c_addr;
            cpu_byteen = vq[i].c_be;
            cpu_rd     = vq[i].c_rd;
            dma_req    = vq[i].d_req;
            dma_addr   = vq[i].d_addr;
            dma_len    = vq[i].d_len;
            dma_we     = vq[i].d_we;
            #4;
            chk($sformatf("v%0d_gnt",    i), dma_gnt,    vq[i].e_gnt);
            chk($sformatf("v%0d_beat",   i), dma_beat,   vq[i].e_beat);
            chk($sformatf("v%0d_rvalid", i), dma_rvalid, vq[i].e_rv);
            chk($sformatf("v%0d_done",   i), dma_done,   vq[i].e_done);
            chk($sformatf("v%0d_maddr",  i), mem_addr,   vq[i].e_addr);
            chk($sformatf("v%0d_mrd",    i), mem_rd,     vq[i].e_rd);
            chk($sformatf("v%0d_mbe",    i), mem_byteen, vq[i].e_be);
            chk($sformatf("v%0d_irq",    i), starve_irq, 1'b0);
            chk($sformatf("v%0d_crdata", i), cpu_rdata,  mem_rdata);
            if (vq[i].e_rv)
                chk($sformatf("v%0d_rdata", i), dma_rdata, vq[i].e_rdata);
            if (vq[i].e_be != 4'h0)
                chk($sformatf("v%0d_wdata", i), mem_wdata, vq[i].e_beat ? DW : CW);
            next_cycle();
        end

        // Length 0 write burst wrapping past 0xFFFFFFFC
        cpu_idle();
        dma_req   = 1'b1;
        dma_addr  = 32'hFFFF_FFF8;
        dma_len   = 5'd0;
        dma_we    = 1'b1;
        exp_a     = 32'hFFFF_FFF8;
        beats     = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            #4;
            if (dma_beat) begin
                chk($sformatf("wrap_addr%0d", beats), mem_addr, exp_a);
                chk($sformatf("wrap_be%0d", beats), mem_byteen, 4'hF);
                exp_a = exp_a + 32'd4;
                beats++;
            end
            if (dma_done) begin
                done_seen = 1'b1;
                chk("wrap_done_beats", beats, 16);
                chk("wrap_done_beat", dma_beat, 1'b0);
            end
            next_cycle();
            if (i >= 1) dma_req = 1'b0;
        end
        chk("wrap_done_seen", done_seen, 1'b1);
        chk("wrap_beats", beats, 16);
        chk("wrap_next_addr", exp_a, 32'h38);
        dma_req = 1'b0;
        next_cycle();

        // Starvation: CPU load held for 10 BURST cycles of a 2-word read burst
        for (int i = 0; i < 15; i++) begin
            cpu_idle();
            dma_req  = (i <= 1);
            dma_addr = 32'h3000;
            dma_len  = 5'd2;
            dma_we   = 1'b0;
            if (i >= 1 && i <= 10) begin
                cpu_rd   = 1'b1;
                cpu_addr = 32'h60;
            end
            #4;
            e_irq = STARVE_EN && (i >= 10) && (i <= 13);
            chk($sformatf("stv%0d_beat", i), dma_beat, (i == 11) || (i == 12));
            chk($sformatf("stv%0d_done", i), dma_done, i == 13);
            chk($sformatf("stv%0d_irq",  i), starve_irq, e_irq);
            if (i >= 1 && i <= 10)
                chk($sformatf("stv%0d_maddr", i), mem_addr, 32'h60);
            next_cycle();
        end

        // Reset in the middle of an 8-word read burst
        cpu_idle();
        dma_req  = 1'b1;
        dma_addr = 32'h1000;
        dma_len  = 5'd8;
        dma_we   = 1'b0;
        next_cycle();
        #4;
        chk("rmb_gnt", dma_gnt, 1'b1);
        chk("rmb_addr0", mem_addr, 32'h1000);
        next_cycle();
        dma_req = 1'b0;
        #4;
        chk("rmb_addr1", mem_addr, 32'h1004);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        #4;
        chk("rmb_beat",   dma_beat,   1'b0);
        chk("rmb_rvalid", dma_rvalid, 1'b0);
        chk("rmb_done",   dma_done,   1'b0);
        chk("rmb_gnt0",   dma_gnt,    1'b0);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            #4;
            chk($sformatf("rmb_idle%0d_done", i), dma_done, 1'b0);
            chk($sformatf("rmb_idle%0d_rv", i), dma_rvalid, 1'b0);
            chk($sformatf("rmb_idle%0d_beat", i), dma_beat, 1'b0);
            next_cycle();
        end
        dma_req  = 1'b1;
        dma_addr = 32'h2000;
        dma_len  = 5'd1;
        #4;
        chk("rmb_req_gnt", dma_gnt, 1'b0);
        next_cycle();
        #4;
        chk("rmb_new_gnt", dma_gnt, 1'b1);
        chk("rmb_new_addr", mem_addr, 32'h2000);
        next_cycle();
        dma_req = 1'b0;
        #4;
        chk("rmb_new_done", dma_done, 1'b1);
        chk("rmb_new_rv", dma_rvalid, 1'b1);
        chk("rmb_new_rdata", dma_rdata, 32'h5A5A2000);
        next_cycle();

        // Back-to-back: request held high through DONE
        bb_gnt  = 6'b010010;
        bb_done = 6'b100100;
        cpu_idle();
        dma_addr = 32'h40;
        dma_len  = 5'd1;
        dma_we   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dma_req = (i <= 4);
            #4;
            chk($sformatf("b2b%0d_gnt", i), dma_gnt, bb_gnt[i]);
            chk($sformatf("b2b%0d_done", i), dma_done, bb_done[i]);
            next_cycle();
        end
        dma_req = 1'b0;
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
